// File: rtl/fifo_sync_fl.sv
// fifo_sync_fl: parametrised single-clock FIFO for the channel data path.
// Programmable almost-full/almost-empty thresholds, synchronous flush (clr),
// sticky overflow/underflow flags and a read-data-valid strobe.
// Optional build macro: FIFO_FWFT_EN selects first-word-fall-through output.
//
// Handshake: a write is taken on any rising edge where wr=1 and the FIFO
// can accept it (!full, or full with a read taken in the same cycle); a read
// is taken on any rising edge where rd=1 and empty=0. Requests that are not
// taken are dropped (not held) and raise the sticky ovf/udf flag instead.
// clr=1 overrides both requests in its cycle.
module fifo_sync_fl #(
  parameter int WBITS     = 8,
  parameter int WORDS     = 4096,
  parameter int AFULL_TH  = WORDS - 4,
  parameter int AEMPTY_TH = 4,
  localparam int AW       = $clog2(WORDS),
  localparam int CW       = $clog2(WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WBITS-1:0] din,
  input  logic             rd,
  output logic [WBITS-1:0] dout,
  output logic             dout_vld,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    cnt,
  output logic             ovf,
  output logic             udf,
  input  logic             err_clr
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
  localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_TH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_TH);

  // Reject illegal configurations at elaboration.
  if (((WORDS & (WORDS - 1)) != 0) || (WORDS < 4) || (AEMPTY_TH <= 0) ||
      (AEMPTY_TH >= AFULL_TH) || (AFULL_TH >= WORDS)) begin : g_bad_params
    $error("fifo_sync_fl: WORDS must be a power of two and 0 < AEMPTY_TH < AFULL_TH < WORDS");
  end

  logic [WBITS-1:0] mem [WORDS];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  logic             rd_ok;
  logic             wr_ok;
  logic             pop;        // advance tail and load dout from mem[tail]
  logic             vld_nxt;
  logic             empty_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [AW-1:0]    head_nxt;
  logic [AW-1:0]    tail_nxt;
  logic             ovf_set;
  logic             udf_set;

`ifdef FIFO_FWFT_EN
  // Words held in the array, excluding the one parked in the dout register.
  logic [CW-1:0]    ram_cnt;
  logic [CW-1:0]    ram_cnt_nxt;
  logic             ram_has;
`endif

  // Accept/reject decisions, next-state count, pointers and flags.
  always_comb begin
    rd_ok    = rd & ~empty & ~clr;
    wr_ok    = wr & ~clr & (~full | rd_ok);
`ifdef FIFO_FWFT_EN
    // dout_vld marks a word parked in the output register; rd acknowledges
    // it. The array refills that register whenever it is free or being
    // acknowledged, which costs one cycle after the write lands.
    ram_has  = (ram_cnt != '0);
    pop      = ram_has & (~dout_vld | rd_ok) & ~clr;
    vld_nxt  = pop | (dout_vld & ~rd_ok);
    ram_cnt_nxt = ram_cnt;
    case ({wr_ok, pop})
      2'b10:   ram_cnt_nxt = ram_cnt + CW'(1);
      2'b01:   ram_cnt_nxt = ram_cnt - CW'(1);
      default: ram_cnt_nxt = ram_cnt;
    endcase
`else
    pop      = rd_ok;
    vld_nxt  = rd_ok;
`endif
    cnt_nxt = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
    head_nxt = wr_ok ? head + AW'(1) : head;
    tail_nxt = pop   ? tail + AW'(1) : tail;
`ifdef FIFO_FWFT_EN
    empty_nxt = ~vld_nxt;
`else
    empty_nxt = (cnt_nxt == '0);
`endif
    if (clr) begin
      cnt_nxt   = '0;
      head_nxt  = '0;
      tail_nxt  = '0;
      vld_nxt   = 1'b0;
      empty_nxt = 1'b1;
`ifdef FIFO_FWFT_EN
      ram_cnt_nxt = '0;
`endif
    end
    ovf_set = wr & full & ~rd_ok & ~clr;
    udf_set = rd & empty & ~clr;
  end

  // Pointer, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      dout_vld     <= 1'b0;
    end else begin
      head         <= head_nxt;
      tail         <= tail_nxt;
      cnt          <= cnt_nxt;
      empty        <= empty_nxt;
      full         <= (cnt_nxt == CNT_FULL);
      almost_full  <= (cnt_nxt >= CNT_AF);
      almost_empty <= (cnt_nxt <= CNT_AE);
      dout_vld     <= vld_nxt;
    end
  end

`ifdef FIFO_FWFT_EN
  // Occupancy of the array behind the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ram_cnt <= '0;
    else      ram_cnt <= ram_cnt_nxt;
  end
`endif

  // Storage array: write port only, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[head] <= din;
  end

  // Registered read port; dout holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     dout <= '0;
    else if (pop) dout <= mem[tail];
  end

  // Sticky error flags; a new error outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~err_clr);
      udf <= udf_set | (udf & ~err_clr);
    end
  end

endmodule
